// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  // Which requester currently owns the memory command.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } arb_state_e;

  // Consecutive data grants allowed while a fetch is waiting.
  localparam int unsigned DEF_MAX_DATA_RUN = 4;

  // Width of a counter that must hold 0..max_run inclusive.
  function automatic int unsigned run_cnt_width(input int unsigned max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_run_counter.sv
// Saturating run counter: counts data grants made while a fetch waits.
module arb_run_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned W = run_cnt_width(DEF_MAX_DATA_RUN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] sat_val,
  output logic         saturated
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, increment stops at sat_val.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < sat_val)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Run count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign saturated = (cnt_q >= sat_val);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins by default; after MAX_DATA_RUN data grants with a fetch waiting,
// the fetch is granted once.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     RW      = run_cnt_width(MAX_DATA_RUN);
  localparam logic [RW-1:0]   SAT_VAL = RW'(MAX_DATA_RUN);

  arb_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic rdy_s, arb_s, if_done_s, d_done_s;
  logic elig_if_s, elig_d_s, gnt_if_s, gnt_d_s, run_sat_s;

  // Completion and arbitration qualifiers; a requester finishing this cycle is not re-eligible.
  always_comb begin
    rdy_s     = mem_rdy & (state_q != ST_IDLE);
    arb_s     = (state_q == ST_IDLE) | rdy_s;
    if_done_s = rdy_s & (state_q == ST_BUSY_IF);
    d_done_s  = rdy_s & (state_q == ST_BUSY_D);
    elig_if_s = if_req & ~if_cancel & ~if_done_s;
    elig_d_s  = d_req & ~d_done_s;
    gnt_d_s   = arb_s & elig_d_s & ~(elig_if_s & run_sat_s);
    gnt_if_s  = arb_s & elig_if_s & ~gnt_d_s;
  end

  arb_run_counter #(.W(RW)) u_run_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .inc       (gnt_d_s & if_req),
    .clr       (gnt_if_s | ~if_req),
    .sat_val   (SAT_VAL),
    .saturated (run_sat_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: move only in arbitration cycles, to the winner or back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_BUSY_IF, ST_BUSY_D: begin
        if (!arb_s) begin
          state_d = state_q;
        end else if (gnt_d_s) begin
          state_d = ST_BUSY_D;
        end else if (gnt_if_s) begin
          state_d = ST_BUSY_IF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture at grant and cancel-drop tracking for an in-flight fetch.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    drop_d      = drop_q;
    if (gnt_d_s) begin
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
    end else if (gnt_if_s) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
    end else begin
      mem_we_d    = mem_we_q;
    end
    if (arb_s) begin
      drop_d = 1'b0;
    end else if ((state_q == ST_BUSY_IF) && if_cancel) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Command and drop registers; a reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      drop_q      <= drop_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs: command from registers, acks and stalls combinational with mem_rdy.
  always_comb begin
    mem_req   = (state_q != ST_IDLE);
    busy      = (state_q != ST_IDLE);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_ack    = if_done_s & ~drop_q & ~if_cancel;
    d_ack     = d_done_s;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    if_stall  = if_req & ~if_ack;
    d_stall   = d_req & ~d_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_rdy, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdy = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    cmp_cnt++; if (mem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp_cnt++; if ({if_ack, d_ack, mem_we} !== 3'b000) begin err_cnt++; $display("FAIL rst_acks_we: got %b want 000", {if_ack, d_ack, mem_we}); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(negedge clk); #1;
    cmp_cnt++; if ({mem_req, busy} !== 2'b11) begin err_cnt++; $display("FAIL rst_pre_busy: got %b want 11", {mem_req, busy}); end
    reset = 1'b0; #1;
    cmp_cnt++; if ({mem_req, busy} !== 2'b00) begin err_cnt++; $display("FAIL rst_async_drop: got %b want 00", {mem_req, busy}); end
    cmp_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    @(negedge clk); reset = 1'b1; d_req = 1'b0;
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
    cmp_cnt++; if ({if_ack, d_ack, busy} !== 3'b000) begin err_cnt++; $display("FAIL rst_no_ack: got %b want 000", {if_ack, d_ack, busy}); end
    @(negedge clk); mem_rdy = 1'b0; #1;
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_stay_idle: got %b want 0", busy); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
    cmp_cnt++; if ({if_stall, mem_req, if_ack} !== 3'b100) begin err_cnt++; $display("FAIL sf_c0: got %b want 100", {if_stall, mem_req, if_ack}); end
    @(negedge clk); #1;
    cmp_cnt++; if ({mem_req, mem_we, if_stall, if_ack} !== 4'b1010) begin err_cnt++; $display("FAIL sf_c1: got %b want 1010", {mem_req, mem_we, if_stall, if_ack}); end
    cmp_cnt++; if (mem_addr !== 32'h40) begin err_cnt++; $display("FAIL sf_addr: got %h want 00000040", mem_addr); end
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'h8C010004; #1;
    cmp_cnt++; if ({if_ack, if_stall} !== 2'b10) begin err_cnt++; $display("FAIL sf_ack: got %b want 10", {if_ack, if_stall}); end
    cmp_cnt++; if (if_rdata !== 32'h8C010004) begin err_cnt++; $display("FAIL sf_rdata: got %h want 8c010004", if_rdata); end
    @(negedge clk); idle_inputs(); #1;
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL sf_idle: got %b want 0", busy); end
  endtask

  task automatic test_conflict();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk); #1;
    cmp_cnt++; if (mem_addr !== 32'h100) begin err_cnt++; $display("FAIL cf_d_first: got %h want 00000100", mem_addr); end
    cmp_cnt++; if ({mem_req, mem_we, if_stall, d_stall} !== 4'b1011) begin err_cnt++; $display("FAIL cf_c1: got %b want 1011", {mem_req, mem_we, if_stall, d_stall}); end
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'h11112222; #1;
    cmp_cnt++; if ({d_ack, if_ack, if_stall} !== 3'b101) begin err_cnt++; $display("FAIL cf_dack: got %b want 101", {d_ack, if_ack, if_stall}); end
    cmp_cnt++; if (d_rdata !== 32'h11112222) begin err_cnt++; $display("FAIL cf_drdata: got %h want 11112222", d_rdata); end
    @(negedge clk); d_req = 1'b0; mem_rdy = 1'b0; #1;
    cmp_cnt++; if ({mem_req, mem_addr, if_stall} !== {1'b1, 32'h44, 1'b1}) begin err_cnt++; $display("FAIL cf_no_bubble: got %b/%h want 1/00000044", mem_req, mem_addr); end
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'h33334444; #1;
    cmp_cnt++; if ({if_ack, if_rdata} !== {1'b1, 32'h33334444}) begin err_cnt++; $display("FAIL cf_ifack: got %b/%h want 1/33334444", if_ack, if_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  // IF is held throughout; a cancel in each data-ack cycle keeps the fetch from
  // winning there, so only the run limit can let it in at an idle arbitration.
  task automatic test_starvation();
    int exp_seq [6] = '{2, 2, 2, 2, 1, 2};
    int got;
    int last_d = 0;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int g = 0; g < 6; g++) begin
      int n = 0;
      @(negedge clk); mem_rdy = 1'b0; if_cancel = 1'b0;
      if (last_d != 0) d_addr = d_addr + 32'h4;
      #1;
      while (mem_req !== 1'b1 && n < 4) begin @(negedge clk); #1; n++; end
      cmp_cnt++; if (mem_req !== 1'b1) begin err_cnt++; $display("FAIL sv_timeout: grant %0d never issued", g); end
      got = (mem_addr == 32'h80) ? 1 : 2;
      cmp_cnt++; if (got != exp_seq[g]) begin err_cnt++; $display("FAIL sv_order: grant %0d got %0d want %0d (1=IF 2=D)", g, got, exp_seq[g]); end
      last_d = (got == 2) ? 1 : 0;
      @(negedge clk); mem_rdy = 1'b1; mem_rdata = $urandom; if_cancel = (got == 2); #1;
      cmp_cnt++; if ({d_ack, if_ack} !== ((got == 2) ? 2'b10 : 2'b01)) begin err_cnt++; $display("FAIL sv_ack: grant %0d got %b", g, {d_ack, if_ack}); end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_cancel();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h60;
    @(negedge clk); if_cancel = 1'b1; if_req = 1'b0; #1;
    cmp_cnt++; if ({mem_req, if_ack} !== 2'b10) begin err_cnt++; $display("FAIL cn_inflight: got %b want 10", {mem_req, if_ack}); end
    @(negedge clk); if_cancel = 1'b0; mem_rdy = 1'b1; mem_rdata = 32'hBAD0BAD0; #1;
    cmp_cnt++; if (if_ack !== 1'b0) begin err_cnt++; $display("FAIL cn_dropped: got %b want 0", if_ack); end
    @(negedge clk); mem_rdy = 1'b0; if_req = 1'b1; if_addr = 32'h80; #1;
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL cn_idle: got %b want 0", busy); end
    @(negedge clk); #1;
    cmp_cnt++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin err_cnt++; $display("FAIL cn_next: got %b/%h want 1/00000080", mem_req, mem_addr); end
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'h12345678; #1;
    cmp_cnt++; if ({if_ack, if_rdata} !== {1'b1, 32'h12345678}) begin err_cnt++; $display("FAIL cn_ack: got %b/%h want 1/12345678", if_ack, if_rdata); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_store();
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      cmp_cnt++; if ({mem_req, mem_we, mem_addr, mem_wdata, d_ack} !== {2'b11, 32'h200, 32'hDEADBEEF, 1'b0}) begin
        err_cnt++; $display("FAIL st_hold: cycle %0d got %b%b/%h/%h ack %b", c, mem_req, mem_we, mem_addr, mem_wdata, d_ack);
      end
    end
    @(negedge clk); mem_rdy = 1'b1; mem_rdata = 32'h0; #1;
    cmp_cnt++; if ({d_ack, d_stall, mem_we} !== 3'b101) begin err_cnt++; $display("FAIL st_ack: got %b want 101", {d_ack, d_stall, mem_we}); end
    @(negedge clk); idle_inputs();
  endtask

  // Random requesters and memory latency; the model tracks the owner of the
  // memory, its command, the pending-drop flag and the data-run count.
  task automatic test_random();
    int owner = 0, run = 0, age = 0, lat = 1, win;
    bit drop = 0, ifp = 0, dp = 0, rdy, e_if, e_d, eif, ed;
    logic [31:0] c_addr = '0, c_wdata = '0;
    bit c_we = 0;
    @(negedge clk); reset = 1'b0; idle_inputs();
    @(negedge clk); reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!ifp && $urandom_range(0, 2) == 0) begin ifp = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
      if_req = ifp; d_req = dp;
      if_cancel = ($urandom_range(0, 9) == 0);
      mem_rdy = (owner != 0) ? (age >= lat) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      #1;
      rdy = mem_rdy && (owner != 0);
      e_if = rdy && owner == 1 && !drop && !if_cancel;
      e_d = rdy && owner == 2;
      cmp_cnt++; if ({if_ack, d_ack} !== {e_if, e_d}) begin err_cnt++; $display("FAIL rnd_acks: cyc %0d got %b want %b", cyc, {if_ack, d_ack}, {e_if, e_d}); end
      cmp_cnt++; if ({if_stall, d_stall} !== {ifp && !e_if, dp && !e_d}) begin err_cnt++; $display("FAIL rnd_stalls: cyc %0d got %b", cyc, {if_stall, d_stall}); end
      cmp_cnt++; if ({mem_req, busy} !== {owner != 0, owner != 0}) begin err_cnt++; $display("FAIL rnd_busy: cyc %0d got %b want owner %0d", cyc, {mem_req, busy}, owner); end
      if (owner != 0) begin
        cmp_cnt++; if ({mem_we, mem_addr} !== {c_we, c_addr}) begin err_cnt++; $display("FAIL rnd_cmd: cyc %0d got %b/%h want %b/%h", cyc, mem_we, mem_addr, c_we, c_addr); end
        if (c_we) begin
          cmp_cnt++; if (mem_wdata !== c_wdata) begin err_cnt++; $display("FAIL rnd_wdata: cyc %0d got %h want %h", cyc, mem_wdata, c_wdata); end
        end
      end
      if (e_if) begin
        cmp_cnt++; if (if_rdata !== mem_rdata) begin err_cnt++; $display("FAIL rnd_ifdata: cyc %0d got %h want %h", cyc, if_rdata, mem_rdata); end
      end
      if (e_d && !c_we) begin
        cmp_cnt++; if (d_rdata !== mem_rdata) begin err_cnt++; $display("FAIL rnd_ddata: cyc %0d got %h want %h", cyc, d_rdata, mem_rdata); end
      end
      win = -1;
      if (owner == 0 || rdy) begin
        eif = ifp && !if_cancel && !(rdy && owner == 1);
        ed = dp && !(rdy && owner == 2);
        win = (ed && !(eif && run == MAXR)) ? 2 : (eif ? 1 : 0);
        drop = 0;
      end else if (owner == 1 && if_cancel) begin
        drop = 1;
      end
      if (!ifp || win == 1) run = 0;
      else if (win == 2 && run < MAXR) run++;
      if (win >= 0) begin
        owner = win; age = 0; lat = $urandom_range(1, 3);
        if (win == 2) begin c_we = d_we; c_addr = d_addr; c_wdata = d_wdata; end
        if (win == 1) begin c_we = 0; c_addr = if_addr; end
      end else begin
        age++;
      end
      if (e_d) dp = 0;
      if (e_if || if_cancel) ifp = 0;
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_cancel();
    test_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
